// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment encodings,
// scan states and the slot-counter width helper.
package seg7_scan_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // seg[6:0] = g..a, active-high
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to seven-segment decoder.
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode hex display scanner with per-frame snapshot of value,
// inter-digit blanking gap and optional leading-zero suppression.
//
// state | meaning
// IDLE  | display dark, waiting for enable
// GAP   | all digits off at the start of a slot (anti-ghosting)
// SHOW  | current digit lit with its shadow nibble
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int WIDTH              = 8,
  parameter int REFRESH_DIV        = 1000,
  parameter int BLANK_GAP          = 2,
  parameter int LEADING_ZERO_BLANK = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   value,
  input  logic               enable,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] an,
  output logic               frame_done
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CNT_W  = cnt_width(REFRESH_DIV);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (BLANK_GAP > 0) ? CNT_W'(BLANK_GAP - 1) : '0;
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam state_t SLOT_START = (BLANK_GAP > 0) ? ST_GAP : ST_SHOW;

  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $fatal(1, "seg7_scan_display: WIDTH must be a multiple of 4 and at least 4");
  end
  if (REFRESH_DIV <= BLANK_GAP || BLANK_GAP < 0) begin : g_bad_timing
    $fatal(1, "seg7_scan_display: need 0 <= BLANK_GAP < REFRESH_DIV");
  end

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [DIG_W-1:0]   digit, nxt_digit;
  logic [WIDTH-1:0]   shadow, nxt_shadow;
  logic [3:0]         nib;
  logic               lz_blank, all_zero;
  logic [6:0]         dec, nxt_seg;
  logic [DIGITS-1:0]  nxt_an;
  logic               nxt_fd;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      digit      <= '0;
      shadow     <= '0;
      an         <= '1;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      digit      <= nxt_digit;
      shadow     <= nxt_shadow;
      an         <= nxt_an;
      seg        <= nxt_seg;
      frame_done <= nxt_fd;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_digit  = digit;
    nxt_shadow = shadow;
    if (!enable) begin
      nxt_state = ST_IDLE;
      nxt_cnt   = '0;
      nxt_digit = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt_state  = SLOT_START;
          nxt_cnt    = '0;
          nxt_digit  = '0;
          nxt_shadow = value;
        end
        ST_GAP: begin
          nxt_cnt = cnt + CNT_W'(1);
          if (cnt == GAP_LAST) nxt_state = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == SLOT_LAST) begin
            nxt_cnt   = '0;
            nxt_state = SLOT_START;
            if (digit == DIG_LAST) begin
              nxt_digit  = '0;
              nxt_shadow = value;
            end else begin
              nxt_digit = digit + DIG_W'(1);
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
          nxt_digit = '0;
        end
      endcase
    end
  end

  // Walk from the top nibble down so all_zero covers nibbles i..DIGITS-1 when digit i is reached.
  always_comb begin
    nib      = '0;
    lz_blank = 1'b0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (nxt_shadow[4*i +: 4] == 4'h0);
      if (nxt_digit == DIG_W'(i)) begin
        nib      = nxt_shadow[4*i +: 4];
        lz_blank = (LEADING_ZERO_BLANK != 0) && (i > 0) && all_zero;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_comb begin
    nxt_an  = '1;
    nxt_seg = '0;
    nxt_fd  = 1'b0;
    if (nxt_state == ST_SHOW) begin
      nxt_fd = (nxt_digit == DIG_LAST) && (nxt_cnt == SLOT_LAST);
      if (!lz_blank) begin
        nxt_seg = dec;
        for (int i = 0; i < DIGITS; i++) begin
          if (nxt_digit == DIG_W'(i)) nxt_an[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: two instances (plain and leading-zero blanking)
// share clock and inputs; each step compares {an, seg, frame_done} against hand values.
module tb_seg7_scan_display;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = 8'h00;
  logic       enable = 1'b0;
  logic [6:0] seg_n, seg_l;
  logic [1:0] an_n, an_l;
  logic       fd_n, fd_l;
  logic [7:0] code;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.WIDTH(8), .REFRESH_DIV(4), .BLANK_GAP(1), .LEADING_ZERO_BLANK(0)) dut (
    .clk (clk), .reset (reset), .value (value), .enable (enable),
    .seg (seg_n), .an (an_n), .frame_done (fd_n)
  );

  seg7_scan_display #(.WIDTH(8), .REFRESH_DIV(4), .BLANK_GAP(1), .LEADING_ZERO_BLANK(1)) dut_lz (
    .clk (clk), .reset (reset), .value (value), .enable (enable),
    .seg (seg_l), .an (an_l), .frame_done (fd_l)
  );

  task automatic chk(input string tag, input bit lz, input logic [1:0] a,
                     input logic [6:0] s, input logic f);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = lz ? {an_l, seg_l, fd_l} : {an_n, seg_n, fd_n};
    exp = {a, s, f};
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: an/seg/fd = %b/%h/%b, expected %b/%h/%b",
                tag, obs[9:8], obs[7:1], obs[0], a, s, f);
  endtask

  task automatic step(input string tag, input bit lz, input logic [1:0] a,
                      input logic [6:0] s, input logic f);
    @(negedge clk);
    chk(tag, lz, a, s, f);
  endtask

  // One 8-cycle frame: gap, 3 show cycles digit 0, gap, 3 show cycles digit 1 (last has frame_done).
  task automatic frame(input string tag, input bit lz, input logic [1:0] a0, input logic [6:0] s0,
                       input logic [1:0] a1, input logic [6:0] s1);
    step({tag, ":gap0"}, lz, 2'b11, 7'h00, 1'b0);
    repeat (3) step({tag, ":d0"}, lz, a0, s0, 1'b0);
    step({tag, ":gap1"}, lz, 2'b11, 7'h00, 1'b0);
    repeat (2) step({tag, ":d1"}, lz, a1, s1, 1'b0);
    step({tag, ":d1_done"}, lz, a1, s1, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_n", 1'b0, 2'b11, 7'h00, 1'b0);
    chk("reset_lz", 1'b1, 2'b11, 7'h00, 1'b0);
    reset = 1'b1;
    step("idle", 1'b0, 2'b11, 7'h00, 1'b0);

    // basic scan, two consecutive frames
    value  = 8'h3A;
    enable = 1'b1;
    frame("scan1", 1'b0, 2'b10, 7'h77, 2'b01, 7'h4F);
    frame("scan2", 1'b0, 2'b10, 7'h77, 2'b01, 7'h4F);

    // value changes during digit-1 slot; current frame unaffected
    step("snap:gap0", 1'b0, 2'b11, 7'h00, 1'b0);
    repeat (3) step("snap:d0", 1'b0, 2'b10, 7'h77, 1'b0);
    step("snap:gap1", 1'b0, 2'b11, 7'h00, 1'b0);
    value = 8'h3B;
    repeat (2) step("snap:d1", 1'b0, 2'b01, 7'h4F, 1'b0);
    step("snap:d1_done", 1'b0, 2'b01, 7'h4F, 1'b1);
    frame("snap_next", 1'b0, 2'b10, 7'h7C, 2'b01, 7'h4F);

    // leading-zero blanking
    value = 8'h05;
    frame("lz05", 1'b1, 2'b10, 7'h6D, 2'b11, 7'h00);
    value = 8'h00;
    frame("lz00", 1'b1, 2'b10, 7'h3F, 2'b11, 7'h00);
    value = 8'h50;
    frame("lz50", 1'b1, 2'b10, 7'h3F, 2'b01, 7'h6D);

    // enable drop mid-SHOW, then re-enable with a new value
    step("drop:gap0", 1'b0, 2'b11, 7'h00, 1'b0);
    step("drop:d0", 1'b0, 2'b10, 7'h3F, 1'b0);
    enable = 1'b0;
    step("drop:idle", 1'b0, 2'b11, 7'h00, 1'b0);
    step("drop:idle2", 1'b0, 2'b11, 7'h00, 1'b0);
    value  = 8'hFF;
    enable = 1'b1;
    frame("reen", 1'b0, 2'b10, 7'h71, 2'b01, 7'h71);

    // async reset between edges mid-frame
    step("ar:gap0", 1'b0, 2'b11, 7'h00, 1'b0);
    step("ar:d0", 1'b0, 2'b10, 7'h71, 1'b0);
    #2 reset = 1'b0;
    #1 chk("ar:async_n", 1'b0, 2'b11, 7'h00, 1'b0);
    chk("ar:async_lz", 1'b1, 2'b11, 7'h00, 1'b0);
    step("ar:held", 1'b0, 2'b11, 7'h00, 1'b0);
    reset = 1'b1;
    frame("ar:resume", 1'b0, 2'b10, 7'h71, 2'b01, 7'h71);

    // slow counter feeding value: one count per frame, all codes and the FF->00 wrap
    value = 8'h00;
    for (int k = 0; k <= 256; k++) begin
      code = k[7:0];
      frame("cnt", 1'b0, 2'b10, HEX[code[3:0]], 2'b01, HEX[code[7:4]]);
      value = 8'(k + 1);
    end

    // reset pulse mid-frame while fed by the counter
    step("cr:gap0", 1'b0, 2'b11, 7'h00, 1'b0);
    step("cr:d0", 1'b0, 2'b10, 7'h06, 1'b0);
    #2 reset = 1'b0;
    #1 chk("cr:async", 1'b0, 2'b11, 7'h00, 1'b0);
    #1 reset = 1'b1;
    frame("cr:resume", 1'b0, 2'b10, 7'h06, 2'b01, 7'h3F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Downstream consumer of the 8-bit free-running counter `value` bus; drives a multiplexed common-anode hex seven-segment display on the board.
- Snapshots the input once per frame so a display frame never tears.
- Time-multiplexes one hex digit per nibble, with a blanking gap between digits to suppress ghosting.
- Emits a one-cycle frame-done strobe.

Parameters:
- WIDTH, 8: input width in bits; multiple of 4, ≥4; DIGITS = WIDTH/4 (derived localparam).
- REFRESH_DIV, 1000: clk cycles per digit slot (gap + show); must be > BLANK_GAP.
- BLANK_GAP, 2: cycles at the start of each slot with all digits off; 0 disables the gap.
- LEADING_ZERO_BLANK, 0: 1 = suppress leading zero digits; digit 0 is never blanked.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- value, input, WIDTH: number to display (counter output).
- enable, input, 1: 1 = scan; 0 = display dark.
- seg, output, 7: segment drive, active-high; seg[0]=a … seg[6]=g.
- an, output, DIGITS: digit enables, active-low; an[0] = least-significant nibble.
- frame_done, output, 1: one-cycle pulse on the last show cycle of digit DIGITS-1.

Behaviour:
- **Reset (reset=0, async):**
  - Outputs: an = all 1s, seg = 0, frame_done = 0.
  - Internal: state = IDLE, digit index = 0, slot counter = 0, shadow = 0.
- **Registers:** all outputs are registered and reflect the current state/phase (no combinational path from value or enable).
- **States:**
  - IDLE: dark.
  - GAP: an all 1s, seg = 0, for BLANK_GAP cycles.
  - SHOW: one digit lit, for REFRESH_DIV − BLANK_GAP cycles.
- **IDLE → GAP(digit 0):** on the first edge with enable=1. On the same edge shadow <= value. If BLANK_GAP=0, go straight to SHOW.
- **GAP → SHOW:** when the slot counter reaches BLANK_GAP − 1. The counter runs 0..REFRESH_DIV−1 per slot and resets to 0 at each slot start.
- **End of SHOW:** at slot counter = REFRESH_DIV−1.
  - digit = (digit+1) mod DIGITS; next state GAP (or SHOW if BLANK_GAP=0).
  - On wrap to digit 0, shadow <= value (new frame).
- **Show outputs:** an[digit]=0, all other an bits = 1; seg = hex decode of shadow nibble [4·digit+3 : 4·digit].
- **Hex decode (seg[6:0], hex):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Leading-zero blanking:** when LEADING_ZERO_BLANK=1 and digit i>0 has all shadow nibbles i..DIGITS−1 equal to zero, that digit's SHOW slot keeps an all 1s and seg = 0. Slot timing is unchanged.
- **Frame period:** DIGITS·REFRESH_DIV cycles.
- **frame_done:** asserted in the cycle whose edge ends digit DIGITS−1's SHOW.
- **enable falls in any state:** next edge → IDLE with dark outputs; counters and digit clear; shadow holds.
- **Re-enable:** always starts a fresh frame at digit 0 with a new snapshot.
- **Changes to value mid-frame:** ignored until the next frame snapshot. Counter wrap FF→00 needs no special handling.
- **Reset released mid-frame:** behaves as from IDLE.
- **Elaboration checks:** illegal parameters (WIDTH%4≠0, REFRESH_DIV≤BLANK_GAP) stop elaboration with $error / $fatal.

Decomposition:
- Shared package holds:
  - the 16-entry seven-segment hex encoding constants;
  - state encoding localparams (IDLE/GAP/SHOW);
  - a helper for the slot-counter width ($clog2(REFRESH_DIV)).
- One natural sub-module: hex_to_seg7, a combinational 4-bit → 7-bit decoder, instantiated once on the muxed nibble.
- Scan FSM, prescaler and shadow register stay in seg7_scan_display.

Test Plan:
All scenarios use WIDTH=8, REFRESH_DIV=4, BLANK_GAP=1 unless stated.
1. **Async reset:** assert reset=0 between clock edges with enable=1 → an=2'b11, seg=0, frame_done=0 immediately, before the next edge.
2. **Basic scan:** value=8'h3A, enable rises → sequence repeats every 8 cycles with frame_done=1 only on the final 7'h4F cycle:
   - 1 cycle an=11;
   - 3 cycles an=10, seg=7'h77;
   - 1 cycle an=11;
   - 3 cycles an=01, seg=7'h4F.
3. **Snapshot:** value 3A→3B during the digit-1 slot → current frame still shows 77/4F; next frame digit 0 shows 7'h7C.
4. **Leading-zero blanking (LEADING_ZERO_BLANK=1):**
   - value=8'h05 → digit-1 slot an=11 throughout, digit 0 shows 7'h6D.
   - value=8'h00 → digit 0 shows 7'h3F.
   - value=8'h50 → both digits lit (6D on digit 1, 3F on digit 0).
5. **Enable drop:** enable=0 mid-SHOW → next edge an=11, seg=0, no frame_done. Re-enable with value=8'hFF → restarts at digit 0 with 7'h71 after the 1-cycle gap.
6. **Counter integration:** connect to the counter's 8-bit value, clocked slowly, reset pulsed mid-frame → every code 00..FF decodes correctly across wrap; a reset mid-frame blanks the display and the scan resumes at digit 0.
